stim_sequencer: RTL and testbench

- Synthesizable, parametrised stimulus player for conquest-style regression benches.
- Holds a programmable table of stimulus vectors. Each vector carries:
  - a DATA_W payload (e.g. key||state for AES = 256),
  - an observation bit,
  - a per-entry hold count.
- Plays the table to the DUT over a valid/ready handshake, in one-shot or loop mode.
- Replaces free-running testbench program counters. Sits between bench/host loader and the DUT top.

---
 rtl/stim_seq_pkg.sv | 38 +++
 rtl/stim_seq_table.sv | 36 +++
 rtl/stim_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_stim_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_seq_pkg.sv
// Shared types and helpers for the stimulus sequencer: FSM state encoding,
// table-entry field offsets and the 32-bit XOR fold used by the optional
// response checksum (built when STIM_SEQ_CKSUM_EN is defined).
package stim_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        HOLD,
        DONE
    } state_t;

    // Entry layout is {hold, obs, payload}; payload sits at bit 0.
    localparam int PAYLOAD_LSB = 0;

    function automatic int obs_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int hold_lsb(input int data_w);
        return data_w + 1;
    endfunction

    // Callers zero-extend their data to FOLD_MAX_W; zero slices leave the
    // XOR unchanged, so one function serves any payload width up to this.
    localparam int FOLD_MAX_W = 1024;

    function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
            r = r ^ d[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/stim_seq_table.sv
// Stimulus table: DEPTH x ENTRY_W storage, synchronous write, registered read.
// Latency: rd_data valid the cycle after rd_en; it holds while rd_en is low.
// Backpressure: none; out-of-range write addresses are dropped.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr/rd_data read port.
module stim_seq_table #(
    parameter  int DEPTH   = 16,
    parameter  int ENTRY_W = 265,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_data_q;

    // No reset on the array or its output register so the storage maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= MAX_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus player: replays a programmable vector table to a DUT, one-shot or looping.
// Latency: start at edge N gives out_valid after edge N+2; >=2 idle cycles between vectors.
// Backpressure: out_data/out_obs/pc hold while out_ready=0, no timeout; stop aborts.
// Ports: clk/rst; wr_* table load (ignored while busy); start/stop/loop_en/last_addr
// control; out_valid/out_ready/out_data/out_obs stream; pc/busy/done/loops status.
// Macro STIM_SEQ_CKSUM_EN adds resp_data in and a rolling cksum out.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter  int DATA_W  = 256,
    parameter  int DEPTH   = 16,
    parameter  int HOLD_W  = 8,
    parameter  int LOOP_W  = 16,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ENTRY_W = HOLD_W + 1 + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [ADDR_W-1:0]  last_addr,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef STIM_SEQ_CKSUM_EN
    input  logic [DATA_W-1:0]  resp_data,
    output logic [31:0]        cksum,
`endif
    output logic [DATA_W-1:0]  out_data,
    output logic               out_obs,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic [LOOP_W-1:0]  loops
);

    localparam int                OBS_BIT   = obs_bit(DATA_W);
    localparam int                HOLD_LSB  = hold_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [LOOP_W-1:0] LOOPS_MAX = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic               loop_q, loop_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_obs_q, out_obs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tbl_wr_en;
    logic               rd_en;
    logic [ENTRY_W-1:0] rd_data;
    logic [DATA_W-1:0]  rd_payload;
    logic               rd_obs;
    logic [HOLD_W-1:0]  rd_hold;
    logic               start_acc;
    logic               advance;

    // The table is frozen during playback so the entry being presented
    // cannot change under the DUT.
    assign tbl_wr_en  = wr_en && !busy_q;
    assign start_acc  = (state_q == IDLE) && start && !stop;
    assign rd_payload = rd_data[PAYLOAD_LSB +: DATA_W];
    assign rd_obs     = rd_data[OBS_BIT];
    assign rd_hold    = rd_data[HOLD_LSB +: HOLD_W];

    stim_seq_table #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (pc_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_d      = last_q;
        loop_d      = loop_q;
        loops_d     = loops_q;
        hold_cnt_d  = hold_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_obs_d   = out_obs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        advance     = 1'b0;

        if (stop && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        loop_d  = loop_en;
                        last_d  = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
                        pc_d    = '0;
                        loops_d = '0;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    rd_en   = 1'b1;
                    state_d = PRESENT;
                end
                PRESENT: begin
                    // First PRESENT cycle captures the table output into the
                    // output registers; valid is only raised once they hold it.
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = rd_payload;
                        out_obs_d   = rd_obs;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (rd_hold == '0) begin
                            advance = 1'b1;
                        end else begin
                            hold_cnt_d = rd_hold;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        advance = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (advance) begin
                if (pc_q != last_q) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH;
                end else if (loop_q) begin
                    pc_d    = '0;
                    loops_d = (loops_q == LOOPS_MAX) ? loops_q : loops_q + LOOP_W'(1);
                    state_d = FETCH;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            loops_q     <= '0;
            hold_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_obs_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            loops_q     <= loops_d;
            hold_cnt_q  <= hold_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_obs_q   <= out_obs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_obs   = out_obs_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign loops     = loops_q;

`ifdef STIM_SEQ_CKSUM_EN
    logic [31:0]           cksum_q, cksum_d;
    logic [FOLD_MAX_W-1:0] resp_ext;

    always_comb begin
        resp_ext = FOLD_MAX_W'(resp_data);
        cksum_d  = cksum_q;
        if (start_acc) begin
            cksum_d = '0;
        end else if (out_valid_q && out_ready) begin
            cksum_d = {cksum_q[30:0], cksum_q[31]} ^ fold32(resp_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: expected vectors are queued when a run
// is launched; a negedge monitor compares every presented vector and its
// leading idle gap. Optional checksum port checked when STIM_SEQ_CKSUM_EN is set.
module tb_stim_sequencer;

    localparam int DATA_W  = 64;
    localparam int DEPTH   = 12;
    localparam int HOLD_W  = 4;
    localparam int LOOP_W  = 2;
    localparam int ADDR_W  = 4;
    localparam int ENTRY_W = HOLD_W + 1 + DATA_W;
    localparam int BUDGET  = 3000;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic [ADDR_W-1:0]  last_addr;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_obs;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;
    logic [LOOP_W-1:0]  loops;
`ifdef STIM_SEQ_CKSUM_EN
    logic [DATA_W-1:0]  resp_data;
    logic [31:0]        cksum;
    logic [31:0]        ck_model;
    bit                 resp_fixed;
`endif

    always #5 clk = ~clk;

    stim_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .last_addr (last_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STIM_SEQ_CKSUM_EN
        .resp_data (resp_data),
        .cksum     (cksum),
`endif
        .out_data  (out_data),
        .out_obs   (out_obs),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .loops     (loops)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              obs;
        logic [ADDR_W-1:0] pc;
        int                gap;
    } exp_t;

    exp_t exp_q[$];

    // Reference copy of the table contents.
    logic [DATA_W-1:0] m_pay  [DEPTH];
    logic              m_obs  [DEPTH];
    int                m_hold [DEPTH];

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int gap_cnt      = 0;
    bit new_item     = 1'b1;
    bit mon_en       = 1'b0;

    bit                 pend_wr   = 1'b0;
    logic [ADDR_W-1:0]  pend_addr = '0;
    logic [ENTRY_W-1:0] pend_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

`ifdef STIM_SEQ_CKSUM_EN
    function automatic logic [31:0] fold_ref(input logic [DATA_W-1:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 32; i++) r = r ^ d[32*i +: 32];
        return r;
    endfunction
`endif

    // Monitor: compares whatever the DUT presents against the queue head.
    initial begin
        exp_t h;
`ifdef STIM_SEQ_CKSUM_EN
        ck_model = '0;
`endif
        forever begin
            @(negedge clk);
            if (mon_en) begin
`ifdef STIM_SEQ_CKSUM_EN
                check("cksum", cksum, ck_model);
                if (rst || start) ck_model = '0;
                else if (out_valid && out_ready)
                    ck_model = {ck_model[30:0], ck_model[31]} ^ fold_ref(resp_data);
`endif
                if (rst) begin
                    gap_cnt  = 0;
                    new_item = 1'b1;
                end else begin
                    if (done) done_cnt++;
                    if (start) begin
                        gap_cnt  = 0;
                        new_item = 1'b1;
                    end else if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_valid", 1, 0);
                        end else begin
                            h = exp_q[0];
                            if (new_item) begin
                                check("idle_gap", gap_cnt, h.gap);
                                new_item = 1'b0;
                            end
                            check("out_data", out_data, h.data);
                            check("out_obs", out_obs, h.obs);
                            check("pc", pc, h.pc);
                            if (out_ready) begin
                                void'(exp_q.pop_front());
                                gap_cnt  = 0;
                                new_item = 1'b1;
                            end
                        end
                    end else begin
                        gap_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [DATA_W-1:0] p, input logic o,
                               input int h);
        logic [HOLD_W-1:0] hb;
        hb      = HOLD_W'(h);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = {hb, o, p};
        if (a < DEPTH) begin
            m_pay[a]  = p;
            m_obs[a]  = o;
            m_hold[a] = h;
        end
        tick();
        wr_en = 1'b0;
    endtask

    // rmode: 0 ready always, 1 random ready, 2 stall entry 1 for 5 cycles.
    task automatic run(input logic [ADDR_W-1:0] last, input bit lp, input int passes,
                       input int rmode, input bit junk_wr);
        int   eff, n, prev, budget, bp, full, exp_loops;
        bit   junk_done;
        exp_t e;
        eff  = (int'(last) > DEPTH - 1) ? DEPTH - 1 : int'(last);
        n    = lp ? passes * (eff + 1) : eff + 1;
        prev = 0;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx    = k % (eff + 1);
            e.data = m_pay[idx];
            e.obs  = m_obs[idx];
            e.pc   = ADDR_W'(idx);
            e.gap  = (k == 0) ? 2 : m_hold[prev] + 2;
            exp_q.push_back(e);
            prev = idx;
        end
        done_cnt  = 0;
        start     = 1'b1;
        loop_en   = lp;
        last_addr = last;
        wr_en     = pend_wr;
        wr_addr   = pend_addr;
        wr_data   = pend_data;
        pend_wr   = 1'b0;
        out_ready = (rmode != 2);
        tick();
        start     = 1'b0;
        wr_en     = 1'b0;
        budget    = 0;
        bp        = 0;
        junk_done = 1'b0;
        while (budget < BUDGET) begin
            if (lp ? (exp_q.size() == 0) : (exp_q.size() == 0 && !busy)) break;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && pc == 1 && bp < 5) begin
                        out_ready = 1'b0;
                        bp++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
`ifdef STIM_SEQ_CKSUM_EN
            if (!resp_fixed) resp_data = {$urandom, $urandom};
`endif
            if (junk_wr && !junk_done && out_valid) begin
                wr_en     = 1'b1;
                wr_addr   = '0;
                wr_data   = '1;
                junk_done = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            budget++;
        end
        wr_en = 1'b0;
        check("run_complete", budget < BUDGET, 1);
        if (lp) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("stop_busy", busy, 0);
            check("stop_valid", out_valid, 0);
            full      = passes - ((m_hold[eff] > 0) ? 1 : 0);
            exp_loops = (full > 3) ? 3 : full;
            check("loops_count", loops, exp_loops);
            repeat (3) tick();
            check("stop_no_done", done_cnt, 0);
        end else begin
            repeat (2) tick();
            check("done_pulses", done_cnt, 1);
            check("busy_after", busy, 0);
            check("loops_oneshot", loops, 0);
            check("pc_final", pc, eff);
        end
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_c;
        exp_t e;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        stop = 1'b0; loop_en = 1'b0; last_addr = '0; out_ready = 1'b0;
`ifdef STIM_SEQ_CKSUM_EN
        resp_data = '0; resp_fixed = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            m_pay[i] = '0; m_obs[i] = 1'b0; m_hold[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_obs", out_obs, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_loops", loops, 0);

        // Clear the whole table so every entry has a known model value.
        for (int i = 0; i < DEPTH; i++) write_entry(i, '0, 1'b0, 0);

        // One-shot.
        write_entry(0, 64'hA0, 1'b1, 0);
        write_entry(1, 64'hA1, 1'b0, 0);
        write_entry(2, 64'hA2, 1'b1, 0);
`ifdef STIM_SEQ_CKSUM_EN
        resp_fixed = 1'b1;
        resp_data  = 64'h1;
`endif
        run(4'd2, 1'b0, 1, 0, 1'b0);
`ifdef STIM_SEQ_CKSUM_EN
        check("cksum_three_ones", cksum, 32'h7);
        resp_fixed = 1'b0;
`endif

        // Backpressure on entry 1.
        run(4'd2, 1'b0, 1, 2, 1'b0);

        // Hold of 3 after entry 0.
        write_entry(0, 64'hA0, 1'b1, 3);
        run(4'd2, 1'b0, 1, 0, 1'b0);
        write_entry(0, 64'hA0, 1'b1, 0);

        // Loop: 3 passes, then 5 passes to hit the saturating counter.
        run(4'd1, 1'b1, 3, 0, 1'b0);
        run(4'd1, 1'b1, 5, 1, 1'b0);

        // Write while busy is dropped; the old entry 0 must replay.
        run(4'd2, 1'b0, 1, 0, 1'b1);
        write_entry(13, 64'hDEAD, 1'b1, 0);
        run(4'd2, 1'b0, 1, 0, 1'b0);

        // Write together with start in IDLE: the new data is played.
        pend_wr   = 1'b1;
        pend_addr = '0;
        pend_data = {4'd0, 1'b0, 64'h55AA_0000_1234_5678};
        m_pay[0]  = 64'h55AA_0000_1234_5678;
        m_obs[0]  = 1'b0;
        m_hold[0] = 0;
        run(4'd2, 1'b0, 1, 0, 1'b0);

        // Randomized table and runs (last_addr beyond DEPTH-1 is clamped).
        for (int i = 0; i < DEPTH; i++)
            write_entry(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)));
        for (int it = 0; it < 6; it++) begin
            run(ADDR_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 2)), 1, 1'b0);
        end
        run(4'd15, 1'b0, 1, 1, 1'b0);

        // Reset while presenting.
        e.data = m_pay[0]; e.obs = m_obs[0]; e.pc = '0; e.gap = 2;
        exp_q.push_back(e);
        out_ready = 1'b0;
        start     = 1'b1;
        loop_en   = 1'b0;
        last_addr = 4'd3;
        tick();
        start  = 1'b0;
        wait_c = 0;
        while (!out_valid && wait_c < 20) begin
            tick();
            wait_c++;
        end
        check("rst_mid_reached_present", out_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_obs", out_obs, 0);
        check("rst_mid_pc", pc, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_loops", loops, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
